// File: rtl/conv_job_sequencer_pkg.sv
// Shared types and constants for the convolution job sequencer.
// Optional feature macro: CONV_SEQ_PERF_CNT_EN (cycle counter at offset 0x1C).
package conv_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ISSUE = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } seq_state_e;

   localparam logic [4:0] RegGie    = 5'h00;
   localparam logic [4:0] RegIer    = 5'h04;
   localparam logic [4:0] RegCtrl   = 5'h08;
   localparam logic [4:0] RegAck    = 5'h0C;
   localparam logic [4:0] RegPend   = 5'h10;
   localparam logic [4:0] RegDim    = 5'h14;
   localparam logic [4:0] RegStatus = 5'h18;
   localparam logic [4:0] RegPerf   = 5'h1C;

   localparam int unsigned PendDone  = 0;
   localparam int unsigned PendAbort = 1;
   localparam int unsigned PendErr   = 2;

endpackage

// File: rtl/conv_job_sequencer_if.sv
// Register bus and pixel request/result signals of the convolution job sequencer.
// master = host/datapath side, slave = sequencer.
interface conv_job_sequencer_if #(
   parameter int unsigned ADDR_W = 20
) ();

   logic              cfg_wr_en;
   logic              cfg_rd_en;
   logic [4:0]        cfg_addr;
   logic [31:0]       cfg_wdata;
   logic [31:0]       cfg_rdata;
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_win;
   logic              res_valid;

   modport master (
      output cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata, rd_ready, res_valid,
      input  cfg_rdata, rd_valid, rd_addr, rd_win
   );

   modport slave (
      input  cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata, rd_ready, res_valid,
      output cfg_rdata, rd_valid, rd_addr, rd_win
   );

endinterface

// File: rtl/conv_job_sequencer_irq_ctrl.sv
// Interrupt controller: GIE/IER enables, PEND sticky bits with W1C ACK, registered level irq.
// A set pulse beats an ACK of the same bit in the same cycle.
module conv_irq_ctrl
   import conv_seq_pkg::*;
(
   input  logic       ACLK,
   input  logic       ARESET,
   input  logic       wr_en,
   input  logic [4:0] addr,
   input  logic [2:0] wdata,
   input  logic [2:0] set,
   output logic       gie,
   output logic [2:0] ier,
   output logic [2:0] pend,
   output logic       irq
);

   logic [2:0] ack;

   always_comb begin
      ack = 3'b000;
      if (wr_en && addr == RegAck) ack = wdata;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         gie  <= 1'b0;
         ier  <= 3'b000;
         pend <= 3'b000;
         irq  <= 1'b0;
      end else begin
         if (wr_en && addr == RegGie) gie <= wdata[0];
         if (wr_en && addr == RegIer) ier <= wdata;
         pend <= (pend & ~ack) | set;
         irq  <= gie & (|(pend & ier));
      end
   end

endmodule

// File: rtl/conv_job_sequencer.sv
// Walks a WxH image in raster order, one pixel request per cycle, tags full KxK windows,
// counts results and raises done/abort/error interrupts. Macro: CONV_SEQ_PERF_CNT_EN.
module conv_job_sequencer
   import conv_seq_pkg::*;
#(
   parameter int unsigned KERNEL = 3,
   parameter int unsigned DIM_W  = 16,
   parameter int unsigned ADDR_W = 20
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   conv_job_sequencer_if.slave  bus,
   output logic                 busy,
   output logic                 irq
);

   localparam int unsigned CNT_W = 2 * DIM_W;
   localparam logic [DIM_W-1:0] KDim = DIM_W'(KERNEL);
   localparam logic [DIM_W-1:0] KM1  = DIM_W'(KERNEL - 1);
   localparam logic [DIM_W-1:0] One  = DIM_W'(1);
   localparam logic [CNT_W-1:0] KExt = CNT_W'(KERNEL - 1);

   seq_state_e        state;
   logic [DIM_W-1:0]  dim_w, dim_h, col, row;
   logic [CNT_W-1:0]  expected, out_cnt;
   logic [2:0]        set_pulse;
   logic              rd_valid_q, rd_win_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [31:0]       rdata_q, rdata_nxt, perf_rd;
   logic              gie;
   logic [2:0]        ier, pend;

   logic             ctrl_wr, do_start, do_abort, accept, last_pix, cnt_en;
   logic [DIM_W-1:0] col_nxt, row_nxt;
   logic [CNT_W-1:0] span_w, span_h, exp_calc;

   function automatic logic win_at(input logic [DIM_W-1:0] c, input logic [DIM_W-1:0] r);
      return (c >= KM1) && (r >= KM1);
   endfunction

   assign busy          = (state == ISSUE) || (state == DRAIN);
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.rd_win    = rd_win_q;
   assign bus.cfg_rdata = rdata_q;

   always_comb begin
      ctrl_wr  = bus.cfg_wr_en && (bus.cfg_addr == RegCtrl);
      // Abort only means something mid-job; otherwise a combined write is a plain start.
      do_abort = ctrl_wr && bus.cfg_wdata[1] && busy;
      do_start = ctrl_wr && bus.cfg_wdata[0] && (state == IDLE);
      accept   = rd_valid_q && bus.rd_ready;
      last_pix = (col == dim_w - One) && (row == dim_h - One);
      cnt_en   = busy && bus.res_valid && (out_cnt != expected);
      if (col == dim_w - One) begin
         col_nxt = '0;
         row_nxt = row + One;
      end else begin
         col_nxt = col + One;
         row_nxt = row;
      end
      span_w   = {{DIM_W{1'b0}}, dim_w} - KExt;
      span_h   = {{DIM_W{1'b0}}, dim_h} - KExt;
      exp_calc = span_w * span_h;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= IDLE;
         dim_w      <= '0;
         dim_h      <= '0;
         col        <= '0;
         row        <= '0;
         expected   <= '0;
         out_cnt    <= '0;
         set_pulse  <= 3'b000;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         rd_win_q   <= 1'b0;
      end else begin
         set_pulse <= 3'b000;
         if (bus.cfg_wr_en && bus.cfg_addr == RegDim && !busy) begin
            dim_w <= bus.cfg_wdata[DIM_W-1:0];
            dim_h <= bus.cfg_wdata[16 +: DIM_W];
         end
         if (cnt_en) out_cnt <= out_cnt + CNT_W'(1);
         if (do_abort) begin
            state                <= IDLE;
            rd_valid_q           <= 1'b0;
            set_pulse[PendAbort] <= 1'b1;
         end else begin
            unique case (state)
               IDLE: if (do_start) state <= CHECK;
               CHECK: begin
                  if (dim_w < KDim || dim_h < KDim) begin
                     state              <= DONE;
                     set_pulse[PendErr] <= 1'b1;
                  end else begin
                     state      <= ISSUE;
                     col        <= '0;
                     row        <= '0;
                     out_cnt    <= '0;
                     expected   <= exp_calc;
                     rd_valid_q <= 1'b1;
                     rd_addr_q  <= '0;
                     rd_win_q   <= win_at('0, '0);
                  end
               end
               ISSUE: begin
                  if (accept) begin
                     if (last_pix) begin
                        rd_valid_q <= 1'b0;
                        state      <= DRAIN;
                     end else begin
                        col       <= col_nxt;
                        row       <= row_nxt;
                        // Raster order makes row*W+col a running increment.
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        rd_win_q  <= win_at(col_nxt, row_nxt);
                     end
                  end
               end
               DRAIN: begin
                  if (out_cnt == expected) begin
                     state               <= DONE;
                     set_pulse[PendDone] <= 1'b1;
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef CONV_SEQ_PERF_CNT_EN
   logic [31:0] perf_cnt;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         perf_cnt <= '0;
      end else if (do_start) begin
         perf_cnt <= '0;
      end else if (busy && perf_cnt != 32'hFFFF_FFFF) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end

   assign perf_rd = perf_cnt;
`else
   assign perf_rd = 32'h0;
`endif

   always_comb begin
      rdata_nxt = 32'h0;
      case (bus.cfg_addr)
         RegGie:    rdata_nxt = {31'h0, gie};
         RegIer:    rdata_nxt = {29'h0, ier};
         RegPend:   rdata_nxt = {29'h0, pend};
         RegDim:    rdata_nxt = {{(16 - DIM_W){1'b0}}, dim_h, {(16 - DIM_W){1'b0}}, dim_w};
         RegStatus: rdata_nxt = {25'h0, state, 3'b000, busy};
         RegPerf:   rdata_nxt = perf_rd;
         default:   rdata_nxt = 32'h0;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rdata_q <= 32'h0;
      end else if (bus.cfg_rd_en) begin
         rdata_q <= rdata_nxt;
      end
   end

   conv_irq_ctrl u_irq_ctrl (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .wr_en  (bus.cfg_wr_en),
      .addr   (bus.cfg_addr),
      .wdata  (bus.cfg_wdata[2:0]),
      .set    (set_pulse),
      .gie    (gie),
      .ier    (ier),
      .pend   (pend),
      .irq    (irq)
   );

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed bench for conv_job_sequencer: raster walk, stalls, dim error, abort, ACK race, reset.
// Honours CONV_SEQ_PERF_CNT_EN for the 0x1C expectation.
module tb_conv_job_sequencer;
   import conv_seq_pkg::*;

   logic ACLK;
   logic ARESET;
   logic busy;
   logic irq;

   conv_job_sequencer_if #(.ADDR_W(20)) bus ();

   conv_job_sequencer #(
      .KERNEL (3),
      .DIM_W  (16),
      .ADDR_W (20)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus),
      .busy   (busy),
      .irq    (irq)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
      bus.cfg_wr_en = 1'b1;
      bus.cfg_addr  = addr;
      bus.cfg_wdata = data;
      tick();
      bus.cfg_wr_en = 1'b0;
   endtask

   task automatic cfg_read(input logic [4:0] addr, output logic [31:0] data);
      bus.cfg_rd_en = 1'b1;
      bus.cfg_addr  = addr;
      tick();
      bus.cfg_rd_en = 1'b0;
      data = bus.cfg_rdata;
   endtask

   // 5x4 job with K=3: 20 reads, windows at (col>=2,row>=2) -> 6, expected results 6.
   task automatic run_job(input bit stall, input bit ack_in_done, input string tag);
      int n_acc = 0, res_sent = 0, win_cnt = 0, stalls = 0;
      int addr_err = 0, win_err = 0, hold_err = 0;
      bit prev_stall = 1'b0;
      bit ready, exp_win;
      logic [19:0] held_addr = '0;
      logic held_win = 1'b0;
      logic [31:0] rd;
      cfg_write(RegCtrl, 32'h1);
      for (int cyc = 0; cyc < 200 && n_acc < 20; cyc++) begin
         if (prev_stall && (!bus.rd_valid || bus.rd_addr != held_addr || bus.rd_win != held_win))
            hold_err++;
         ready = stall ? cyc[0] : 1'b1;
         bus.rd_ready = ready;
         if (bus.rd_valid && ready) begin
            exp_win = ((n_acc % 5) >= 2) && ((n_acc / 5) >= 2);
            if (32'(bus.rd_addr) != n_acc) addr_err++;
            if (bus.rd_win != exp_win) win_err++;
            if (bus.rd_win) win_cnt++;
            n_acc++;
         end
         if (bus.rd_valid && !ready) stalls++;
         bus.res_valid = bus.rd_valid && (res_sent < 6);
         if (bus.res_valid) res_sent++;
         prev_stall = bus.rd_valid && !ready;
         held_addr  = bus.rd_addr;
         held_win   = bus.rd_win;
         tick();
      end
      bus.res_valid = 1'b0;
      bus.rd_ready  = 1'b0;
      check_eq({tag, "_reads"}, 32'(n_acc), 32'd20);
      check_eq({tag, "_addr_seq_errs"}, 32'(addr_err), 32'd0);
      check_eq({tag, "_win_count"}, 32'(win_cnt), 32'd6);
      check_eq({tag, "_win_errs"}, 32'(win_err), 32'd0);
      if (stall) begin
         check_eq({tag, "_hold_errs"}, 32'(hold_err), 32'd0);
         check_eq({tag, "_stalls_seen"}, 32'(stalls > 0), 32'd1);
      end
      check_eq({tag, "_drain_valid"}, 32'(bus.rd_valid), 32'd0);
      check_eq({tag, "_drain_busy"}, 32'(busy), 32'd1);
      tick();
      // Now in DONE; an ACK of bit 0 here races the done set.
      if (ack_in_done) begin
         bus.cfg_wr_en = 1'b1;
         bus.cfg_addr  = RegAck;
         bus.cfg_wdata = 32'h1;
      end
      tick();
      bus.cfg_wr_en = 1'b0;
      check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_irq_latency"}, 32'(irq), 32'd0);
      tick();
      check_eq({tag, "_irq"}, 32'(irq), 32'd1);
      cfg_read(RegPend, rd);
      check_eq({tag, "_pend"}, rd, 32'h1);
   endtask

   logic [31:0] rd;
   int bad_valid;

   initial begin
      ARESET        = 1'b1;
      bus.cfg_wr_en = 1'b0;
      bus.cfg_rd_en = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;
      bus.rd_ready  = 1'b0;
      bus.res_valid = 1'b0;
      repeat (3) tick();
      ARESET = 1'b0;

      check_eq("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check_eq("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_irq", 32'(irq), 32'd0);
      check_eq("rst_rdata", bus.cfg_rdata, 32'd0);
      cfg_read(RegStatus, rd);
      check_eq("rst_status", rd, 32'h0);

      cfg_write(RegDim, {16'd4, 16'd5});
      cfg_read(RegDim, rd);
      check_eq("dim_readback", rd, 32'h0004_0005);
      cfg_write(RegGie, 32'h1);
      cfg_write(RegIer, 32'h1);

      run_job(1'b0, 1'b0, "job");
      cfg_read(RegPerf, rd);
`ifdef CONV_SEQ_PERF_CNT_EN
      check_eq("perf_cycles", rd, 32'd21);
`else
      check_eq("perf_absent", rd, 32'd0);
`endif
      cfg_write(RegAck, 32'h7);
      tick();
      check_eq("ack_irq_clear", 32'(irq), 32'd0);

      run_job(1'b1, 1'b1, "stall_ack");
      cfg_write(RegAck, 32'h7);
      tick();

      // Undersized image: error path, no requests.
      cfg_write(RegDim, {16'd8, 16'd2});
      cfg_write(RegIer, 32'h4);
      cfg_write(RegCtrl, 32'h1);
      bad_valid = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.rd_valid) bad_valid++;
         tick();
      end
      check_eq("err_no_valid", 32'(bad_valid), 32'd0);
      cfg_read(RegPend, rd);
      check_eq("err_pend", rd, 32'h4);
      check_eq("err_irq", 32'(irq), 32'd1);
      cfg_write(RegAck, 32'h4);
      tick();
      check_eq("err_irq_clear", 32'(irq), 32'd0);
      cfg_read(RegPend, rd);
      check_eq("err_pend_clear", rd, 32'h0);

      // Abort after 7 accepted reads, with a redundant start mid-job.
      cfg_write(RegDim, {16'd4, 16'd5});
      cfg_write(RegIer, 32'h7);
      begin
         int n_acc = 0, addr_err = 0;
         cfg_write(RegCtrl, 32'h1);
         for (int cyc = 0; cyc < 50 && n_acc < 7; cyc++) begin
            bus.rd_ready  = 1'b1;
            bus.cfg_wr_en = 1'b0;
            if (bus.rd_valid) begin
               if (32'(bus.rd_addr) != n_acc) addr_err++;
               n_acc++;
               if (n_acc == 4) begin
                  bus.cfg_wr_en = 1'b1;
                  bus.cfg_addr  = RegCtrl;
                  bus.cfg_wdata = 32'h1;
               end
            end
            tick();
         end
         bus.cfg_wr_en = 1'b0;
         check_eq("abort_reads", 32'(n_acc), 32'd7);
         check_eq("abort_addr_errs", 32'(addr_err), 32'd0);
         check_eq("abort_pre_addr", 32'(bus.rd_addr), 32'd7);
      end
      bus.rd_ready = 1'b0;
      cfg_write(RegCtrl, 32'h3);
      check_eq("abort_valid", 32'(bus.rd_valid), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      tick();
      cfg_read(RegPend, rd);
      check_eq("abort_pend", rd, 32'h2);
      check_eq("abort_still_idle", 32'(bus.rd_valid), 32'd0);
      cfg_write(RegAck, 32'h7);

      // Reset during DRAIN: no results returned so the job parks there.
      cfg_write(RegCtrl, 32'h1);
      bus.rd_ready = 1'b1;
      repeat (25) tick();
      bus.rd_ready = 1'b0;
      cfg_read(RegStatus, rd);
      check_eq("drain_status", rd, 32'h31);
      cfg_read(RegDim, rd);
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      check_eq("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
      check_eq("mid_rst_addr", 32'(bus.rd_addr), 32'd0);
      check_eq("mid_rst_win", 32'(bus.rd_win), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_rdata", bus.cfg_rdata, 32'd0);
      tick();
      tick();
      check_eq("mid_rst_irq", 32'(irq), 32'd0);
      cfg_read(RegDim, rd);
      check_eq("mid_rst_dim", rd, 32'h0);
      cfg_read(RegPend, rd);
      check_eq("mid_rst_pend", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
